// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//   Byte-command run controller that sits between the UART byte streams and
//   the RISC-V core. Decodes single-byte commands (R/H/S/B/C/P/X), gates the
//   core clock enable, drives the core reset and returns one response byte
//   per command.
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   rx_data_i/valid/ready   command/operand byte stream (ready is registered)
//   tx_data_o/valid/ready   response byte stream (data/valid registered)
//   pc_i                    current core PC
//   cpu_clk_en_o            core clock enable (combinational outside STEP/CRST)
//   cpu_rst_o               active-high core reset
//   running_o               free-run flag
//   bp_hit_o                sticky breakpoint-hit status
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int PC_W         = 8,
  parameter int RST_CYCLES   = 4,
  parameter int OPND_TIMEOUT = 65535
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [7:0]      rx_data_i,
  input  logic            rx_valid_i,
  output logic            rx_ready_o,
  output logic [7:0]      tx_data_o,
  output logic            tx_valid_o,
  input  logic            tx_ready_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            cpu_clk_en_o,
  output logic            cpu_rst_o,
  output logic            running_o,
  output logic            bp_hit_o
);

  localparam int TMO_W = (OPND_TIMEOUT < 2) ? 1 : $clog2(OPND_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(OPND_TIMEOUT - 1);

  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;
  localparam logic [7:0] OP_R  = 8'h52;
  localparam logic [7:0] OP_H  = 8'h48;
  localparam logic [7:0] OP_S  = 8'h53;
  localparam logic [7:0] OP_B  = 8'h42;
  localparam logic [7:0] OP_C  = 8'h43;
  localparam logic [7:0] OP_P  = 8'h50;
  localparam logic [7:0] OP_X  = 8'h58;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPERAND = 3'd1,
    S_STEP    = 3'd2,
    S_CRST    = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t           r_state,    w_state_nxt;
  logic             r_rx_ready, w_rx_ready_nxt;
  logic [7:0]       r_tx_data,  w_tx_data_nxt;
  logic             r_tx_valid, w_tx_valid_nxt;
  logic             r_cpu_rst,  w_cpu_rst_nxt;
  logic             r_run,      w_run_nxt;
  logic             r_skip,     w_skip_nxt;
  logic             r_bp_en,    w_bp_en_nxt;
  logic [PC_W-1:0]  r_bp_addr,  w_bp_addr_nxt;
  logic             r_bp_hit,   w_bp_hit_nxt;
  logic             r_op_step,  w_op_step_nxt;   // 1: pending operand is N, 0: bp address
  logic [7:0]       r_cnt,      w_cnt_nxt;       // step count or reset-cycle count
  logic [TMO_W-1:0] r_tmo,      w_tmo_nxt;

  logic       w_accept;
  logic       w_match;
  logic       w_clk_en;
  logic       w_resp_go;
  logic [7:0] w_resp_byte;

  assign w_accept = rx_valid_i && r_rx_ready;
  // skip suppresses the match for one enabled cycle so a resume at the
  // breakpoint address executes that instruction
  assign w_match  = r_bp_en && r_run && !r_skip && (pc_i == r_bp_addr);

  // Core clock enable: counted in STEP, forced in CRST, free-run otherwise
  always_comb begin
    w_clk_en = 1'b0;
    case (r_state)
      S_STEP:  w_clk_en = (r_cnt != 8'd0);
      S_CRST:  w_clk_en = 1'b1;
      default: w_clk_en = r_run && !w_match;
    endcase
  end

  // Next-state and next-register computation
  always_comb begin
    w_state_nxt    = r_state;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_cpu_rst_nxt  = r_cpu_rst;
    w_run_nxt      = r_run;
    w_skip_nxt     = r_skip;
    w_bp_en_nxt    = r_bp_en;
    w_bp_addr_nxt  = r_bp_addr;
    w_bp_hit_nxt   = r_bp_hit;
    w_op_step_nxt  = r_op_step;
    w_cnt_nxt      = r_cnt;
    w_tmo_nxt      = r_tmo;
    w_resp_go      = 1'b0;
    w_resp_byte    = 8'h00;

    if (w_clk_en) begin
      w_skip_nxt = 1'b0;
    end else begin
      w_skip_nxt = r_skip;
    end

    // Command handling below may override these (e.g. R resumes, C clears hit)
    if (w_match) begin
      w_run_nxt    = 1'b0;
      w_bp_hit_nxt = 1'b1;
    end else begin
      w_run_nxt    = r_run;
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (rx_data_i)
            OP_R: begin
              w_run_nxt   = 1'b1;
              w_skip_nxt  = 1'b1;
              w_resp_go   = 1'b1;
              w_resp_byte = ACK;
            end
            OP_H: begin
              w_run_nxt   = 1'b0;
              w_resp_go   = 1'b1;
              w_resp_byte = ACK;
            end
            OP_S: begin
              w_op_step_nxt = 1'b1;
              w_tmo_nxt     = '0;
              w_state_nxt   = S_OPERAND;
            end
            OP_B: begin
              w_op_step_nxt = 1'b0;
              w_tmo_nxt     = '0;
              w_state_nxt   = S_OPERAND;
            end
            OP_C: begin
              w_bp_en_nxt  = 1'b0;
              w_bp_hit_nxt = 1'b0;
              w_resp_go    = 1'b1;
              w_resp_byte  = ACK;
            end
            OP_P: begin
              w_resp_go   = 1'b1;
              w_resp_byte = pc_i[7:0];
            end
            OP_X: begin
              w_run_nxt     = 1'b0;
              w_cnt_nxt     = 8'(RST_CYCLES);
              w_cpu_rst_nxt = 1'b1;
              w_state_nxt   = S_CRST;
            end
            default: begin
              w_resp_go   = 1'b1;
              w_resp_byte = NAK;
            end
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_OPERAND: begin
        if (w_accept) begin
          if (r_op_step) begin
            w_run_nxt = 1'b0;
            // N=0 answers straight away with the current PC
            if (rx_data_i == 8'd0) begin
              w_resp_go   = 1'b1;
              w_resp_byte = pc_i[7:0];
            end else begin
              w_cnt_nxt   = rx_data_i;
              w_state_nxt = S_STEP;
            end
          end else begin
            w_bp_addr_nxt = PC_W'(rx_data_i);
            w_bp_en_nxt   = 1'b1;
            w_bp_hit_nxt  = 1'b0;
            w_resp_go     = 1'b1;
            w_resp_byte   = ACK;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_resp_go   = 1'b1;
          w_resp_byte = NAK;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end

      // Trailing cycle with cnt==0 lets pc_i reflect the last step
      S_STEP: begin
        if (r_cnt == 8'd0) begin
          w_resp_go   = 1'b1;
          w_resp_byte = pc_i[7:0];
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      S_CRST: begin
        if (r_cnt <= 8'd1) begin
          w_cpu_rst_nxt = 1'b0;
          w_resp_go     = 1'b1;
          w_resp_byte   = ACK;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      S_RESP: begin
        if (tx_ready_i) begin
          w_tx_valid_nxt = 1'b0;
          w_state_nxt    = S_IDLE;
        end else begin
          w_tx_valid_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_resp_go) begin
      w_state_nxt    = S_RESP;
      w_tx_valid_nxt = 1'b1;
      w_tx_data_nxt  = w_resp_byte;
    end else begin
      w_tx_data_nxt  = w_tx_data_nxt;
    end

    // Ready drops for one cycle after every accepted byte
    w_rx_ready_nxt = ((w_state_nxt == S_IDLE) || (w_state_nxt == S_OPERAND)) && !w_accept;
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_rx_ready <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_cpu_rst  <= 1'b0;
      r_run      <= 1'b0;
      r_skip     <= 1'b0;
      r_bp_en    <= 1'b0;
      r_bp_addr  <= '0;
      r_bp_hit   <= 1'b0;
      r_op_step  <= 1'b0;
      r_cnt      <= 8'd0;
      r_tmo      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rx_ready <= w_rx_ready_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_cpu_rst  <= w_cpu_rst_nxt;
      r_run      <= w_run_nxt;
      r_skip     <= w_skip_nxt;
      r_bp_en    <= w_bp_en_nxt;
      r_bp_addr  <= w_bp_addr_nxt;
      r_bp_hit   <= w_bp_hit_nxt;
      r_op_step  <= w_op_step_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tmo      <= w_tmo_nxt;
    end
  end

  assign rx_ready_o   = r_rx_ready;
  assign tx_data_o    = r_tx_data;
  assign tx_valid_o   = r_tx_valid;
  assign cpu_clk_en_o = w_clk_en;
  assign cpu_rst_o    = r_cpu_rst;
  assign running_o    = r_run;
  assign bp_hit_o     = r_bp_hit;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_ctrl
//   Directed bench for cpu_run_ctrl. A tiny core model advances pc on each
//   enabled clock; expected response bytes are queued when a command is sent
//   and compared when the controller hands the byte over.
// -----------------------------------------------------------------------------
module tb_cpu_run_ctrl;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] pc = 8'h00;
  logic       cpu_clk_en;
  logic       cpu_rst;
  logic       running;
  logic       bp_hit;

  logic       pc_set = 1'b0;
  logic [7:0] pc_set_val = 8'h00;

  int en_cnt = 0;
  int rst_cnt = 0;
  int rst_en_cnt = 0;

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] sb_q[$];

  cpu_run_ctrl #(.PC_W(8), .RST_CYCLES(4), .OPND_TIMEOUT(TMO)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .pc_i        (pc),
    .cpu_clk_en_o(cpu_clk_en),
    .cpu_rst_o   (cpu_rst),
    .running_o   (running),
    .bp_hit_o    (bp_hit)
  );

  always #5 clk = ~clk;

  // Core model: reset zeroes pc, each enabled clock advances it
  always @(posedge clk) begin
    if (pc_set) pc <= pc_set_val;
    else if (cpu_rst) pc <= 8'h00;
    else if (cpu_clk_en) pc <= pc + 8'd1;
  end

  // Cycle counters for enable and reset pulses
  always @(posedge clk) begin
    if (cpu_clk_en) en_cnt <= en_cnt + 1;
    if (cpu_rst) rst_cnt <= rst_cnt + 1;
    if (cpu_rst && cpu_clk_en) rst_en_cnt <= rst_en_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pc(input logic [7:0] v);
    pc_set_val = v;
    pc_set = 1'b1;
    @(negedge clk);
    pc_set = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted
  task automatic send(input logic [7:0] b);
    int k;
    k = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rx_ready_wait", (k < 100) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic recv(input string tag);
    int k;
    logic [7:0] exp;
    k = 0;
    while (!tx_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_tx_wait"}, (k < 200) ? 32'd1 : 32'd0, 32'd1);
    check({tag, "_sb_nonempty"}, (sb_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'h00;
    check(tag, {24'd0, tx_data}, {24'd0, exp});
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    check({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd0);
    check({tag, "_running"}, {31'd0, running}, 32'd0);
    check({tag, "_bp_hit"}, {31'd0, bp_hit}, 32'd0);
    check({tag, "_clk_en"}, {31'd0, cpu_clk_en}, 32'd0);
  endtask

  initial begin
    int e0;
    int k;

    // Reset and release
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    check("rx_ready_first_cycle", {31'd0, rx_ready}, 32'd0);
    @(negedge clk);
    check("rx_ready_idle", {31'd0, rx_ready}, 32'd1);

    // P readback
    set_pc(8'h3C);
    sb_q.push_back(8'h3C);
    send(8'h50);
    recv("P_pc3c");

    // S 5
    set_pc(8'h20);
    e0 = en_cnt;
    sb_q.push_back(8'h25);
    send(8'h53);
    send(8'h05);
    recv("S5_pc");
    check("S5_en_cycles", en_cnt - e0, 32'd5);
    check("S5_en_off", {31'd0, cpu_clk_en}, 32'd0);

    // S 0
    e0 = en_cnt;
    sb_q.push_back(8'h25);
    send(8'h53);
    send(8'h00);
    recv("S0_pc");
    check("S0_en_cycles", en_cnt - e0, 32'd0);

    // Breakpoint at 0x10, run from 0x08
    set_pc(8'h08);
    sb_q.push_back(8'h06);
    send(8'h42);
    send(8'h10);
    recv("B_ack");
    sb_q.push_back(8'h06);
    send(8'h52);
    recv("R_ack");
    k = 0;
    while (running && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("bp_stop_wait", (k < 500) ? 32'd1 : 32'd0, 32'd1);
    check("bp_pc", {24'd0, pc}, 32'h10);
    check("bp_clk_en", {31'd0, cpu_clk_en}, 32'd0);
    check("bp_hit", {31'd0, bp_hit}, 32'd1);
    check("bp_running", {31'd0, running}, 32'd0);
    @(negedge clk);
    check("bp_pc_held", {24'd0, pc}, 32'h10);

    // Resume at the breakpoint passes it
    sb_q.push_back(8'h06);
    send(8'h52);
    recv("R_resume");
    check("resume_passed", (pc > 8'h10) ? 32'd1 : 32'd0, 32'd1);
    check("resume_running", {31'd0, running}, 32'd1);
    check("resume_hit_sticky", {31'd0, bp_hit}, 32'd1);

    // C while running, then R; no further halt across a pc wrap
    sb_q.push_back(8'h06);
    send(8'h43);
    recv("C_ack");
    check("C_hit_clr", {31'd0, bp_hit}, 32'd0);
    sb_q.push_back(8'h06);
    send(8'h52);
    recv("R_again");
    repeat (300) @(negedge clk);
    check("noBP_running", {31'd0, running}, 32'd1);
    check("noBP_hit", {31'd0, bp_hit}, 32'd0);
    sb_q.push_back(8'h06);
    send(8'h48);
    recv("H_ack");
    check("H_running", {31'd0, running}, 32'd0);
    check("H_clk_en", {31'd0, cpu_clk_en}, 32'd0);

    // X core reset
    e0 = rst_en_cnt;
    k = rst_cnt;
    sb_q.push_back(8'h06);
    send(8'h58);
    recv("X_ack");
    check("X_rst_en_cycles", rst_en_cnt - e0, 32'd4);
    check("X_rst_cycles", rst_cnt - k, 32'd4);
    check("X_running", {31'd0, running}, 32'd0);
    check("X_pc_zero", {24'd0, pc}, 32'd0);

    // Unknown opcode
    sb_q.push_back(8'h15);
    send(8'h77);
    recv("NAK_77");

    // Operand timeout
    sb_q.push_back(8'h15);
    send(8'h53);
    recv("S_timeout");

    // Back-pressure: response held stable
    sb_q.push_back(8'h06);
    send(8'h48);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, tx_valid}, 32'd1);
      check("hold_data", {24'd0, tx_data}, 32'h06);
    end
    recv("hold_H");

    // Reset during STEP
    set_pc(8'h40);
    send(8'h53);
    send(8'd200);
    repeat (3) @(negedge clk);
    check("step_active", {31'd0, cpu_clk_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_pc(8'h5A);
    sb_q.push_back(8'h5A);
    send(8'h50);
    recv("P_after_rst");

    check("sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
